cic_comb_sequencer: RTL
=======================

CIC_COMB_SEQUENCER -- requirements
Module: cic_comb_sequencer

Interface
REQ-001 Parameter IW, default 19, input sample width in bits.
REQ-002 Parameter OW, default 19, output sample width in bits; OW >= IW SHALL hold.
REQ-003 Parameter N, default 3, comb differential delay in decimated samples.
REQ-004 Parameter NCH, default 4, number of microphone channels sharing the one comb datapath.
REQ-005 Parameter R, default 16, decimation ratio; R >= NCH+1 SHALL hold.
REQ-006 lr_clock  input  1  sole clock, rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 i_valid  input  1  one-cycle strobe marking a new integrator sample on all channels.
REQ-009 i_data  input  NCH*IW  packed integrator outputs; channel k occupies bits [k*IW+IW-1 : k*IW].
REQ-010 o_data  output  OW  comb result, registered.
REQ-011 o_channel  output  clog2(NCH) (min 1)  channel index of o_data.
REQ-012 o_valid  output  1  o_data/o_channel valid for exactly this cycle.
REQ-013 overrun  output  1  sticky flag: a decimation tick was dropped.
REQ-014 clr_overrun  input  1  synchronous clear of overrun.

Function
REQ-015 Decimation counter dec_cnt (0..R-1) SHALL increment on each edge with i_valid=1 and wrap from R-1 to 0; it SHALL NOT change when i_valid=0.
REQ-016 A tick SHALL be an edge where i_valid=1 and dec_cnt==R-1.
REQ-017 FSM states SHALL be IDLE and RUN, with channel index ch in 0..NCH-1.
REQ-018 On a tick accepted in IDLE: all NCH samples latch into a holding register, state goes to RUN, ch goes to 0.
REQ-019 Each edge in RUN SHALL:
- compute y = sext(hold[ch]) - sext(dly[ch][N-1]);
- register y to o_data, ch to o_channel, and 1 to o_valid;
- shift channel ch's delay line (dly[ch][0] <= hold[ch]);
- increment ch.
REQ-020 After processing ch==NCH-1, state SHALL return to IDLE.
REQ-021 o_valid SHALL be 0 on every edge that does not process a channel.
REQ-022 Latency: for a tick at edge t, channel k result SHALL be valid in the cycle after edge t+1+k; the NCH results are contiguous and ordered 0..NCH-1.
REQ-023 Each channel SHALL have a private N-deep delay line; channels are never mixed.
REQ-024 Arithmetic SHALL be two's complement:
- inputs sign-extended to OW;
- subtraction wraps modulo 2^OW;
- no saturation.
REQ-025 A tick arriving on the same edge that processes ch==NCH-1 SHALL be accepted as if in IDLE (back-to-back, no gap).
REQ-026 A tick arriving in RUN with ch != NCH-1 SHALL be dropped:
- holding register unchanged;
- current sequence completes normally;
- overrun set to 1;
- dec_cnt still wraps.
REQ-027 overrun SHALL stay 1 until clr_overrun=1 or reset; if set and clear coincide, set wins.
REQ-028 i_data SHALL be sampled only on accepted ticks; other changes have no effect.

Reset
REQ-029 While reset=1, the following SHALL be 0 immediately and asynchronously: dec_cnt, state=IDLE, ch, holding register, all delay lines, o_data, o_channel, o_valid, overrun.
REQ-030 Reset asserted mid-sequence SHALL abort the sequence; no further o_valid until a new tick after release.
REQ-031 The first N outputs per channel after reset SHALL equal the sign-extended sample minus 0.

Verification
REQ-032 Reset, then 16 i_valid strobes with ch0..3 = 10, 20, 30, 40 -> o_valid high 4 consecutive cycles; o_channel 0..3; o_data 10, 20, 30, 40.
REQ-033 Ticks with ch0 = 5, 7, 9, 100 (N=3) -> ch0 outputs 5, 7, 9, then 95.
REQ-034 ch1 = -262144 (IW=OW=19) against a delayed value of 1 -> o_data wraps to 262143.
REQ-035 Tick on the edge processing ch3 -> new sequence starts next cycle with no o_valid gap; overrun stays 0.
REQ-036 Tick while ch=1 -> overrun=1; outputs unchanged; next accepted tick is processed normally; clr_overrun=1 returns overrun to 0.
REQ-037 Reset asserted at ch=2 -> all outputs 0 at once; after release, the next sequence shows each channel minus 0.

Source files
------------

// File: rtl/cic_comb_sequencer.sv
// cic_comb_sequencer
//   Time-multiplexed CIC comb stage shared by NCH microphone channels.
//   Every R-th integrator strobe (a "tick") latches all channel samples into
//   a holding register; the sequencer then walks the channels one per cycle,
//   producing y = x[n] - x[n-N] for each, with a private N-deep delay line
//   per channel. Results appear on o_data/o_channel with a one-cycle o_valid.
//
// Ports
//   lr_clock     sole clock, rising edge
//   reset        asynchronous, active-high reset
//   i_valid      one-cycle strobe: new integrator sample on all channels
//   i_data       packed integrator outputs, channel k at [k*IW +: IW]
//   o_data       registered comb result (OW bits, two's complement)
//   o_channel    channel index of o_data
//   o_valid      o_data/o_channel valid for this cycle only
//   overrun      sticky: a tick arrived mid-sequence and was dropped
//   clr_overrun  synchronous clear of overrun (a coincident set wins)

// Per-channel comb delay line: shifts only on the cycle its channel is served.
module cic_comb_dly #(
    parameter int IW = 19,
    parameter int N  = 3
) (
    input  logic          lr_clock,
    input  logic          reset,
    input  logic          shift,
    input  logic [IW-1:0] din,
    output logic [IW-1:0] tap
);
    logic [N-1:0][IW-1:0] dly;

    always_ff @(posedge lr_clock or posedge reset) begin
        if (reset) begin
            dly <= '0;
        end else if (shift) begin
            dly[0] <= din;
            for (int i = 1; i < N; i++) dly[i] <= dly[i-1];
        end
    end

    assign tap = dly[N-1];
endmodule

module cic_comb_sequencer #(
    parameter int IW  = 19,
    parameter int OW  = 19,
    parameter int N   = 3,
    parameter int NCH = 4,
    parameter int R   = 16,
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              lr_clock,
    input  logic              reset,
    input  logic              i_valid,
    input  logic [NCH*IW-1:0] i_data,
    output logic [OW-1:0]     o_data,
    output logic [CW-1:0]     o_channel,
    output logic              o_valid,
    output logic              overrun,
    input  logic              clr_overrun
);
    localparam int DW = (R > 1) ? $clog2(R) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state, state_nxt;
    logic [CW-1:0]           ch, ch_nxt;
    logic [DW-1:0]           dec_cnt;
    logic [NCH-1:0][IW-1:0]  hold;
    logic [NCH-1:0][IW-1:0]  taps;
    logic                    run, last_ch, tick, accept, drop;
    logic signed [IW-1:0]    cur_s, old_s;
    logic [OW-1:0]           diff;

    assign run     = (state == RUN);
    assign last_ch = (ch == CW'(NCH-1));
    assign tick    = i_valid && (dec_cnt == DW'(R-1));
    // A tick landing on the final channel's cycle chains straight into the
    // next sequence; anywhere else mid-sequence it would clobber hold.
    assign accept  = tick && (!run || last_ch);
    assign drop    = tick && run && !last_ch;

    always_ff @(posedge lr_clock or posedge reset) begin
        if (reset) begin
            dec_cnt <= '0;
        end else if (i_valid) begin
            dec_cnt <= (dec_cnt == DW'(R-1)) ? '0 : dec_cnt + 1'b1;
        end
    end

    always_ff @(posedge lr_clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ch    <= '0;
        end else begin
            state <= state_nxt;
            ch    <= ch_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ch_nxt    = ch;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = RUN;
                    ch_nxt    = '0;
                end
            end
            RUN: begin
                if (last_ch) begin
                    state_nxt = accept ? RUN : IDLE;
                    ch_nxt    = '0;
                end else begin
                    ch_nxt = ch + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                ch_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge lr_clock or posedge reset) begin
        if (reset) begin
            hold <= '0;
        end else if (accept) begin
            hold <= i_data;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        cic_comb_dly #(.IW(IW), .N(N)) u_dly (
            .lr_clock (lr_clock),
            .reset    (reset),
            .shift    (run && (ch == CW'(k))),
            .din      (hold[k]),
            .tap      (taps[k])
        );
    end

    // Size casts of signed operands sign-extend; the OW-bit subtract wraps.
    assign cur_s = hold[ch];
    assign old_s = taps[ch];
    assign diff  = OW'(cur_s) - OW'(old_s);

    always_ff @(posedge lr_clock or posedge reset) begin
        if (reset) begin
            o_data    <= '0;
            o_channel <= '0;
            o_valid   <= 1'b0;
        end else begin
            o_valid <= run;
            if (run) begin
                o_data    <= diff;
                o_channel <= ch;
            end
        end
    end

    always_ff @(posedge lr_clock or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end
endmodule
